siso_frame_deser: RTL and testbench

Serial frame deserializer that sits directly downstream of the structural SISO shift chain and consumes its serial output bit stream. It detects a start bit, shifts in DATA_W data bits LSB-first, optionally checks a parity bit and the stop bit, and presents each completed word on a one-entry valid/ready output buffer. Framing, parity and overrun faults are reported as single-cycle pulses or word-qualified flags.

---
 rtl/siso_frame_deser_if.sv | 19 +
 rtl/siso_frame_deser.sv | 77 +++++++
 tb/tb_siso_frame_deser.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/siso_frame_deser_if.sv
// siso_frame_deser_if: serial input, bit strobe and one-entry valid/ready word output of the frame deserializer
interface siso_frame_deser_if #(parameter int unsigned DATA_W = 8);
    logic              sin;
    logic              sin_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    modport master (
        output sin, sin_en, dout_ready,
        input  dout, dout_valid, parity_err, frame_err, overrun
    );
    modport slave (
        input  sin, sin_en, dout_ready,
        output dout, dout_valid, parity_err, frame_err, overrun
    );
endinterface

// File: rtl/siso_frame_deser.sv
// siso_frame_deser: start/data/parity/stop serial frame receiver with a one-word valid/ready output buffer
module siso_frame_deser #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned ODD_PARITY = 0
) (
    input logic clk,
    input logic rst,
    siso_frame_deser_if.slave bus
);
    localparam int unsigned CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sr;
    logic              perr;
    logic              stop_edge, good, load;
    assign stop_edge = bus.sin_en && state == STOP;
    assign good      = stop_edge && !bus.sin;
    assign load      = good && (!bus.dout_valid || bus.dout_ready);
    // next state: advance only on strobed edges
    always_comb begin
        state_nx = state;
        if (bus.sin_en) begin
            case (state)
                IDLE:    state_nx = bus.sin ? DATA : IDLE;
                DATA:    state_nx = (cnt == LAST) ? ((PARITY_EN != 0) ? PARITY : STOP) : DATA;
                PARITY:  state_nx = STOP;
                default: state_nx = IDLE;
            endcase
        end
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // bit counter, LSB-first shift register and captured parity result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sr   <= '0;
            perr <= 1'b0;
        end else if (bus.sin_en) begin
            case (state)
                IDLE:    cnt <= '0;
                DATA: begin
                    sr  <= {bus.sin, sr[DATA_W-1:1]};
                    cnt <= cnt + 1'b1;
                end
                PARITY:  perr <= (^sr ^ bus.sin) != 1'(ODD_PARITY);
                default: ;
            endcase
        end
    end
    // output buffer: load good frames, drop them on overrun, clear on consume
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.frame_err <= stop_edge && bus.sin;
            bus.overrun   <= good && bus.dout_valid && !bus.dout_ready;
            if (load) begin
                bus.dout       <= sr;
                bus.parity_err <= (PARITY_EN != 0) && perr;
                bus.dout_valid <= 1'b1;
            end else if (bus.dout_ready) begin
                bus.dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_siso_frame_deser.sv
// tb_siso_frame_deser: directed and randomized frame checks against a frame-level reference model
module tb_siso_frame_deser;
    localparam int unsigned ODD = 0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    logic rdy_bg = 1'b0;
    logic       mv = 1'b0;
    logic [7:0] md = '0;
    logic       mp = 1'b0;
    siso_frame_deser_if #(.DATA_W(8)) bus ();
    siso_frame_deser #(.DATA_W(8), .PARITY_EN(1), .ODD_PARITY(ODD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic ep(input logic [7:0] d, input logic p);
        return ((($countones(d) + int'(p)) % 2) != int'(ODD));
    endfunction
    task automatic drive(input logic s, input logic en, input logic r);
        @(negedge clk);
        bus.sin = s;
        bus.sin_en = en;
        bus.dout_ready = r;
        @(posedge clk);
        #1;
    endtask
    task automatic frame(input logic [7:0] d, input logic p, input logic st, input logic rs);
        logic b;
        for (int i = 0; i < 11; i++) begin
            b = (i == 0) ? 1'b1 : (i < 9) ? d[i-1] : (i == 9) ? p : st;
            drive(b, 1'b1, (i == 10) ? rs : rdy_bg);
        end
    endtask
    task automatic drain();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
    endtask
    task automatic test_reset();
        logic [11:0] o;
        #3;
        o = {bus.dout, bus.dout_valid, bus.parity_err, bus.frame_err, bus.overrun};
        vecs++;
        if (o !== 12'h0) begin $display("FAIL reset_values got %h want 000", o); errs++; end
        @(negedge clk);
        rst = 1'b0;
        rdy_bg = 1'b0;
        frame(8'h5A, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h5A) begin
            $display("FAIL pre_reset_word got v=%b d=%h want v=1 d=5a", bus.dout_valid, bus.dout); errs++;
        end
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        o = {bus.dout, bus.dout_valid, bus.parity_err, bus.frame_err, bus.overrun};
        vecs++;
        if (o !== 12'h0) begin $display("FAIL async_reset got %h want 000", o); errs++; end
        @(negedge clk);
        rst = 1'b0;
        frame(8'h5A, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h5A || bus.parity_err !== ep(8'h5A, 1'b0)) begin
            $display("FAIL post_reset_frame got v=%b d=%h p=%b want v=1 d=5a p=0", bus.dout_valid, bus.dout, bus.parity_err); errs++;
        end
        drain();
    endtask
    task automatic test_basic();
        frame(8'hA5, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hA5 || bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) begin
            $display("FAIL basic_frame got v=%b d=%h p=%b fe=%b want v=1 d=a5 p=0 fe=0", bus.dout_valid, bus.dout, bus.parity_err, bus.frame_err); errs++;
        end
        drive(1'b0, 1'b0, 1'b1);
        vecs++;
        if (bus.dout_valid !== 1'b0) begin $display("FAIL basic_consume got v=%b want 0", bus.dout_valid); errs++; end
        drive(1'b0, 1'b0, 1'b0);
    endtask
    task automatic test_parity_err();
        frame(8'hA5, 1'b1, 1'b0, 1'b0);
        vecs++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hA5 || bus.parity_err !== ep(8'hA5, 1'b1)) begin
            $display("FAIL parity_err got v=%b d=%h p=%b want v=1 d=a5 p=1", bus.dout_valid, bus.dout, bus.parity_err); errs++;
        end
        drain();
    endtask
    task automatic test_frame_err();
        frame(8'h3C, 1'b0, 1'b1, 1'b0);
        vecs++;
        if (bus.frame_err !== 1'b1 || bus.dout_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            $display("FAIL frame_err_pulse got fe=%b v=%b ov=%b want fe=1 v=0 ov=0", bus.frame_err, bus.dout_valid, bus.overrun); errs++;
        end
        drive(1'b0, 1'b1, 1'b0);
        vecs++;
        if (bus.frame_err !== 1'b0) begin $display("FAIL frame_err_width got %b want 0", bus.frame_err); errs++; end
        frame(8'h01, 1'b1, 1'b0, 1'b0);
        vecs++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h01 || bus.parity_err !== 1'b0) begin
            $display("FAIL after_frame_err got v=%b d=%h p=%b want v=1 d=01 p=0", bus.dout_valid, bus.dout, bus.parity_err); errs++;
        end
        drain();
    endtask
    task automatic test_overrun();
        rdy_bg = 1'b0;
        frame(8'h11, 1'b0, 1'b0, 1'b0);
        frame(8'h22, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (bus.overrun !== 1'b1 || bus.dout !== 8'h11 || bus.dout_valid !== 1'b1 || bus.frame_err !== 1'b0) begin
            $display("FAIL overrun got ov=%b d=%h v=%b fe=%b want ov=1 d=11 v=1 fe=0", bus.overrun, bus.dout, bus.dout_valid, bus.frame_err); errs++;
        end
        drive(1'b0, 1'b0, 1'b0);
        vecs++;
        if (bus.overrun !== 1'b0 || bus.dout !== 8'h11) begin
            $display("FAIL overrun_width got ov=%b d=%h want ov=0 d=11", bus.overrun, bus.dout); errs++;
        end
        frame(8'h22, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (bus.overrun !== 1'b0 || bus.dout !== 8'h22 || bus.dout_valid !== 1'b1) begin
            $display("FAIL load_on_drain got ov=%b d=%h v=%b want ov=0 d=22 v=1", bus.overrun, bus.dout, bus.dout_valid); errs++;
        end
        drain();
    endtask
    task automatic test_strobe();
        logic [7:0] d;
        logic b;
        d = 8'hC3;
        for (int c = 0; c < 4; c++) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            b = (i == 0) ? 1'b1 : (i < 9) ? d[i-1] : 1'b0;
            for (int c = 0; c < 4; c++) drive((c == 3) ? b : ((c % 2) == 0) ^ b, c == 3, 1'b0);
        end
        vecs++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hC3 || bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) begin
            $display("FAIL strobe_gating got v=%b d=%h p=%b fe=%b want v=1 d=c3 p=0 fe=0", bus.dout_valid, bus.dout, bus.parity_err, bus.frame_err); errs++;
        end
        drain();
    endtask
    task automatic rstep(input logic s, input logic en, input logic last, input logic st, input logic [7:0] d, input logic p);
        logic r, efe, eov, ld;
        r = 1'($urandom);
        drive(s, en, r);
        efe = 1'b0;
        eov = 1'b0;
        ld = 1'b0;
        if (en && last) begin
            if (st) efe = 1'b1;
            else if (mv && !r) eov = 1'b1;
            else ld = 1'b1;
        end
        if (ld) begin
            mv = 1'b1;
            md = d;
            mp = ep(d, p);
        end else if (mv && r) begin
            mv = 1'b0;
        end
        vecs++;
        if (bus.dout_valid !== mv || bus.frame_err !== efe || bus.overrun !== eov) begin
            $display("FAIL random_flags got v=%b fe=%b ov=%b want v=%b fe=%b ov=%b", bus.dout_valid, bus.frame_err, bus.overrun, mv, efe, eov); errs++;
        end
        if (mv) begin
            vecs++;
            if (bus.dout !== md || bus.parity_err !== mp) begin
                $display("FAIL random_word got d=%h p=%b want d=%h p=%b", bus.dout, bus.parity_err, md, mp); errs++;
            end
        end
    endtask
    task automatic test_random();
        logic [7:0] d;
        logic p, st, b, en;
        mv = 1'b0;
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 5) == 0);
            for (int g = $urandom_range(0, 3); g > 0; g--) rstep(1'b0, 1'($urandom), 1'b0, st, d, p);
            for (int i = 0; i < 11; i++) begin
                b = (i == 0) ? 1'b1 : (i < 9) ? d[i-1] : (i == 9) ? p : st;
                en = 1'b0;
                for (int t = 0; !en; t++) begin
                    en = (t == 5) || ($urandom_range(0, 3) != 0);
                    rstep(en ? b : (i == 0 ? 1'b0 : 1'($urandom)), en, i == 10, st, d, p);
                end
            end
        end
        drain();
    endtask
    initial begin
        bus.sin = 1'b0;
        bus.sin_en = 1'b0;
        bus.dout_ready = 1'b0;
        test_reset();
        test_basic();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_strobe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
